// File: rtl/uart_prog_loader.sv
// UART 8N1 image loader: frames bytes into 32-bit words, strobes them to memory, then flags done/err (UPG_CHECKSUM_EN adds a trailing XOR byte).
// Latency: write strobe one cycle after the stop-bit sample of each word's 4th byte; done one cycle after the last strobe.
// Backpressure: none; the memory write is single-cycle and bytes are at least ten bit-times apart.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14
) (
    input  logic              upg_clk_i,
    input  logic              upg_rstn_i,
    input  logic              upg_rx_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);
    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]     N_MAX    = 17'(2 ** ADDR_W);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] FR_HDR0 = 3'd0;
    localparam logic [2:0] FR_HDR1 = 3'd1;
    localparam logic [2:0] FR_DATA = 3'd2;
`ifdef UPG_CHECKSUM_EN
    localparam logic [2:0] FR_CHK  = 3'd3;
`endif
    localparam logic [2:0] FR_DONE = 3'd4;
    localparam logic [2:0] FR_ERR  = 3'd5;

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]       rx_st_q, rx_st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shr_q, shr_d;
    logic             byte_vld_q, byte_vld_d;
    logic             frm_err_q, frm_err_d;

    logic [2:0]        fr_st_q, fr_st_d;
    logic [15:0]       n_q, n_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_word;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shr_d      = shr_q;
        byte_vld_d = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_END) begin
                cnt_d   = '0;
                bit_d   = '0;
                rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == BIT_END) begin
                cnt_d = '0;
                shr_d = {rx_s2_q, shr_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (cnt_q == BIT_END) begin
                // Back to IDLE mid-stop-bit so the next start edge is never missed.
                rx_st_d    = RX_IDLE;
                byte_vld_d = rx_s2_q;
                frm_err_d  = !rx_s2_q;
            end
        endcase
    end

    assign last_word = (17'(adr_q) + 17'd1) == {1'b0, n_q};

    always_comb begin
        fr_st_d = fr_st_q;
        n_d     = n_q;
        asm_d   = asm_q;
        bidx_d  = bidx_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wen_d   = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
`ifdef UPG_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (wen_q) begin
            if (last_word) begin
`ifdef UPG_CHECKSUM_EN
                fr_st_d = FR_CHK;
`else
                fr_st_d = FR_DONE;
                done_d  = 1'b1;
`endif
            end else begin
                adr_d = adr_q + 1'b1;
            end
        end
        if (frm_err_q && fr_st_q != FR_DONE && fr_st_q != FR_ERR) begin
            fr_st_d = FR_ERR;
            err_d   = 1'b1;
        end else if (byte_vld_q) begin
            case (fr_st_q)
                FR_HDR0: begin
                    n_d[7:0] = shr_q;
                    fr_st_d  = FR_HDR1;
                end
                FR_HDR1: begin
                    n_d[15:8] = shr_q;
                    if ({1'b0, shr_q, n_q[7:0]} > N_MAX) begin
                        fr_st_d = FR_ERR;
                        err_d   = 1'b1;
                    end else if ({shr_q, n_q[7:0]} == 16'd0) begin
`ifdef UPG_CHECKSUM_EN
                        fr_st_d = FR_CHK;
`else
                        fr_st_d = FR_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        fr_st_d = FR_DATA;
                    end
                end
                FR_DATA: begin
`ifdef UPG_CHECKSUM_EN
                    chk_d = chk_q ^ shr_q;
`endif
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        dat_d = {shr_q, asm_q};
                        wen_d = 1'b1;
                    end else begin
                        asm_d = {shr_q, asm_q[23:8]};
                    end
                end
`ifdef UPG_CHECKSUM_EN
                FR_CHK: begin
                    if (shr_q == chk_q) begin
                        fr_st_d = FR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        fr_st_d = FR_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i) begin
        if (!upg_rstn_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shr_q      <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            fr_st_q    <= FR_HDR0;
            n_q        <= '0;
            asm_q      <= '0;
            bidx_q     <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            rx_s1_q    <= upg_rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shr_q      <= shr_d;
            byte_vld_q <= byte_vld_d;
            frm_err_q  <= frm_err_d;
            fr_st_q    <= fr_st_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            bidx_q     <= bidx_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UPG_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: randomized UART images checked against a word-list reference model.
// Latency: not applicable. Backpressure: not applicable.
module tb_uart_prog_loader;
    localparam int CPB    = 16;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rstn;
    logic              rx;
    logic              wen;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] img_q[$];
    int          exp_adr[$];
    logic [31:0] exp_dat[$];
    int          got_adr[$];
    logic [31:0] got_dat[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .upg_clk_i (clk),
        .upg_rstn_i(rstn),
        .upg_rx_i  (rx),
        .upg_wen_o (wen),
        .upg_adr_o (adr),
        .upg_dat_o (dat),
        .upg_done_o(done),
        .upg_err_o (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) begin
            got_adr.push_back(int'(adr));
            got_dat.push_back(dat);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rx   = 1'b1;
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rstn = 1'b1;
        got_adr.delete();
        got_dat.delete();
        exp_adr.delete();
        exp_dat.delete();
        img_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat ($urandom_range(3, CPB)) @(posedge clk);
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    // Sends header, every word of img_q little-endian, and the XOR byte when checksums are built in.
    task automatic send_image(input bit bad_chk);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        send_header(16'(img_q.size()));
        foreach (img_q[i]) begin
            w = img_q[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 1'b1);
                x = x ^ w[8*k +: 8];
            end
        end
`ifdef UPG_CHECKSUM_EN
        send_byte(bad_chk ? (x ^ 8'h01) : x, 1'b1);
`else
        if (bad_chk) x = ~x;
`endif
    endtask

    task automatic expect_image();
        foreach (img_q[i]) begin
            exp_adr.push_back(i);
            exp_dat.push_back(img_q[i]);
        end
    endtask

    task automatic verify(input string name, input bit exp_done, input bit exp_err);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check_val({name, ".nwr"}, 64'(got_adr.size()), 64'(exp_adr.size()));
        for (int i = 0; i < exp_adr.size() && i < got_adr.size(); i++) begin
            check_val($sformatf("%s.adr%0d", name, i), 64'(got_adr[i]), 64'(exp_adr[i]));
            check_val($sformatf("%s.dat%0d", name, i), 64'(got_dat[i]), 64'(exp_dat[i]));
        end
        check_val({name, ".done"}, 64'(done), 64'(exp_done));
        check_val({name, ".err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        bit chk_on;
        bit bad;
        int n;
`ifdef UPG_CHECKSUM_EN
        chk_on = 1'b1;
`else
        chk_on = 1'b0;
`endif
        rx   = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.wen", 64'(wen), 64'd0);
        check_val("rst.adr", 64'(adr), 64'd0);
        check_val("rst.dat", 64'(dat), 64'd0);
        check_val("rst.done", 64'(done), 64'd0);
        check_val("rst.err", 64'(err), 64'd0);

        // Two-word image, then trailing bytes that must be ignored once done.
        do_reset();
        img_q.push_back(32'h1234_5678);
        img_q.push_back(32'hDEAD_BEEF);
        send_image(1'b0);
        expect_image();
        verify("img2", 1'b1, 1'b0);
        check_val("img2.adr_hold", 64'(adr), 64'd1);
        send_header(16'd1);
        for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 1'b1);
        verify("img2.after_done", 1'b1, 1'b0);

        do_reset();
        send_image(1'b0);
        verify("empty", 1'b1, 1'b0);

        // Bad stop bit on the first byte of word 1.
        do_reset();
        send_header(16'd3);
        for (int k = 0; k < 4; k++) send_byte(8'(8'hA0 + k), 1'b1);
        send_byte(8'h55, 1'b0);
        for (int k = 0; k < 7; k++) send_byte(8'($urandom), 1'b1);
        exp_adr.push_back(0);
        exp_dat.push_back(32'hA3A2_A1A0);
        verify("framing", 1'b0, 1'b1);

        do_reset();
        rx = 1'b0;
        repeat (CPB * 3 / 10) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        img_q.push_back($urandom);
        send_image(1'b0);
        expect_image();
        verify("glitch", 1'b1, 1'b0);

        // Single-cycle reset after two data bytes, then a fresh one-word image.
        do_reset();
        send_header(16'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rstn = 1'b0;
        @(posedge clk);
        rstn = 1'b1;
        img_q.push_back(32'hCAFE_F00D);
        send_image(1'b0);
        expect_image();
        verify("midreset", 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            bad = chk_on && r[0];
            send_image(bad);
            expect_image();
            verify($sformatf("rand%0d", r), !bad, bad);
            check_val($sformatf("rand%0d.adr_hold", r), 64'(adr), 64'(n - 1));
        end

        do_reset();
        send_header(16'h4001);
        verify("toolong", 1'b0, 1'b1);
        do_reset();
        send_header(16'h4000);
        verify("maxlen_hdr", 1'b0, 1'b0);

`ifdef UPG_CHECKSUM_EN
        do_reset();
        img_q.push_back(32'h0403_0201);
        send_header(16'd1);
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1);
        send_byte(8'h04, 1'b1);
        expect_image();
        verify("chk_ok", 1'b1, 1'b0);
        do_reset();
        img_q.push_back(32'h0403_0201);
        send_header(16'd1);
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1);
        send_byte(8'h05, 1'b1);
        expect_image();
        verify("chk_bad", 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
